sap1_controller: RTL

SAP1_CONTROLLER -- requirements
Module: sap1_controller

---
 rtl/sap1_controller_if.sv | 42 ++++
 rtl/sap1_controller.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/sap1_controller_if.sv
// ============================================================================
// Module   : sap1_controller_if
// Purpose  : Opcode input and control-word outputs of the SAP-1 sequencer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface sap1_controller_if;
    logic [3:0] opcode;
    logic       inc_pc;
    logic       enable_pc;
    logic       load_mar;
    logic       enable_ram;
    logic       load_ir;
    logic       enable_ir;
    logic       load_acc;
    logic       enable_acc;
    logic       alu_sub;
    logic       enable_alu;
    logic       load_b;
    logic       load_out;
    logic       halt;
    logic [5:0] t_state;

    // Controller side
    modport master (
        input  opcode,
        output inc_pc, enable_pc, load_mar, enable_ram, load_ir, enable_ir,
        output load_acc, enable_acc, alu_sub, enable_alu, load_b, load_out,
        output halt, t_state
    );

    // Datapath side
    modport slave (
        output opcode,
        input  inc_pc, enable_pc, load_mar, enable_ram, load_ir, enable_ir,
        input  load_acc, enable_acc, alu_sub, enable_alu, load_b, load_out,
        input  halt, t_state
    );
endinterface

`default_nettype wire

// File: rtl/sap1_controller.sv
// ============================================================================
// Module   : sap1_controller
// Purpose  : Six T-state ring sequencer with combinational control decode.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sap1_controller #(
    parameter logic [3:0] OP_LDA = 4'b0000,
    parameter logic [3:0] OP_ADD = 4'b0001,
    parameter logic [3:0] OP_SUB = 4'b0010,
    parameter logic [3:0] OP_OUT = 4'b1110,
    parameter logic [3:0] OP_HLT = 4'b1111
) (
    input  wire logic          Clock,
    input  wire logic          Reset,
    sap1_controller_if.master  bus
);

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } t_state_e;

    t_state_e r_state;
    logic     r_halted;

    // A halted controller parks in T4 and ignores the opcode until reset.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state  <= T1;
            r_halted <= 1'b0;
        end else if (!r_halted) begin
            case (r_state)
                T1:      r_state <= T2;
                T2:      r_state <= T3;
                T3:      r_state <= T4;
                T4: begin
                    if (bus.opcode == OP_HLT)
                        r_halted <= 1'b1;
                    else
                        r_state  <= T5;
                end
                T5:      r_state <= T6;
                T6:      r_state <= T1;
                default: r_state <= T1;
            endcase
        end
    end

    logic w_is_lda;
    logic w_is_add;
    logic w_is_sub;
    logic w_is_out;

    assign w_is_lda = (bus.opcode == OP_LDA);
    assign w_is_add = (bus.opcode == OP_ADD);
    assign w_is_sub = (bus.opcode == OP_SUB);
    assign w_is_out = (bus.opcode == OP_OUT);

    logic w_inc_pc;
    logic w_enable_pc;
    logic w_load_mar;
    logic w_enable_ram;
    logic w_load_ir;
    logic w_enable_ir;
    logic w_load_acc;
    logic w_enable_acc;
    logic w_alu_sub;
    logic w_enable_alu;
    logic w_load_b;
    logic w_load_out;

    // Opcode is only consulted in T4-T6; reset gates every strobe low at once.
    always_comb begin
        w_inc_pc     = 1'b0;
        w_enable_pc  = 1'b0;
        w_load_mar   = 1'b0;
        w_enable_ram = 1'b0;
        w_load_ir    = 1'b0;
        w_enable_ir  = 1'b0;
        w_load_acc   = 1'b0;
        w_enable_acc = 1'b0;
        w_alu_sub    = 1'b0;
        w_enable_alu = 1'b0;
        w_load_b     = 1'b0;
        w_load_out   = 1'b0;
        if (!Reset && !r_halted) begin
            case (r_state)
                T1: begin
                    w_enable_pc = 1'b1;
                    w_load_mar  = 1'b1;
                end
                T2: begin
                    w_inc_pc = 1'b1;
                end
                T3: begin
                    w_enable_ram = 1'b1;
                    w_load_ir    = 1'b1;
                end
                T4: begin
                    if (w_is_lda || w_is_add || w_is_sub) begin
                        w_enable_ir = 1'b1;
                        w_load_mar  = 1'b1;
                    end else if (w_is_out) begin
                        w_enable_acc = 1'b1;
                        w_load_out   = 1'b1;
                    end
                end
                T5: begin
                    if (w_is_lda) begin
                        w_enable_ram = 1'b1;
                        w_load_acc   = 1'b1;
                    end else if (w_is_add || w_is_sub) begin
                        w_enable_ram = 1'b1;
                        w_load_b     = 1'b1;
                    end
                end
                T6: begin
                    if (w_is_add || w_is_sub) begin
                        w_enable_alu = 1'b1;
                        w_alu_sub    = w_is_sub;
                        w_load_acc   = 1'b1;
                    end
                end
                default: begin
                    w_inc_pc = 1'b0;
                end
            endcase
        end
    end

    assign bus.inc_pc     = w_inc_pc;
    assign bus.enable_pc  = w_enable_pc;
    assign bus.load_mar   = w_load_mar;
    assign bus.enable_ram = w_enable_ram;
    assign bus.load_ir    = w_load_ir;
    assign bus.enable_ir  = w_enable_ir;
    assign bus.load_acc   = w_load_acc;
    assign bus.enable_acc = w_enable_acc;
    assign bus.alu_sub    = w_alu_sub;
    assign bus.enable_alu = w_enable_alu;
    assign bus.load_b     = w_load_b;
    assign bus.load_out   = w_load_out;
    assign bus.halt       = r_halted & ~Reset;
    assign bus.t_state    = r_state;

endmodule

`default_nettype wire
